rd_deserializer: RTL
====================

RD_DESERIALIZER -- requirements
Module: rd_deserializer

Interface
REQ-001 The block SHALL have parameters: WORD_BITS, default 12, data bits per serial word; MAX_WORDS, default 2048, buffer depth in words; ADDR_BITS, default 11, log2(MAX_WORDS).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports in the order below (clock and reset first).
REQ-003 LOCAL_CLK  in  1  Sole clock; all logic on rising edge.
REQ-004 RESET  in  1  Synchronous, active-high reset.
REQ-005 ENABLE_XFR  in  1  Transfer-active strobe from the RD transmitter; synchronous to LOCAL_CLK.
REQ-006 SERIAL_IN0, SERIAL_IN1  in  1 each  Serial data per channel; transmitter changes them on the falling edge.
REQ-007 WR_EN  out  1  Buffer write strobe, one cycle per complete word.
REQ-008 WR_ADDR  out  ADDR_BITS  Buffer write address.
REQ-009 WR_DATA  out  32  Write data: {3'b0, PERR1, DATA1[11:0], 3'b0, PERR0, DATA0[11:0]}.
REQ-010 WORD_COUNT  out  ADDR_BITS+1  Number of complete words written in the current or last transfer.
REQ-011 PERR_COUNT  out  16  Number of words with a parity error on either channel, saturating.
REQ-012 BUSY  out  1  High while in the DATA, PARITY or OVERFLOW states.
REQ-013 XFR_DONE  out  1  One-cycle pulse at the end of a transfer.
REQ-014 TRUNCATED, OVERFLOW  out  1 each  Sticky status flags for the current or last transfer.

Function
REQ-015 The frame SHALL be WORD_BITS data bits, MSB first, followed by one parity bit, 13 cycles per word; parity is odd, i.e. the total number of ones over the 13 bits is odd.
REQ-016 The block SHALL sample SERIAL_IN0/1 and ENABLE_XFR on the rising edge of LOCAL_CLK.
REQ-017 The first rising edge with ENABLE_XFR=1 SHALL carry bit 11 of word 0.
REQ-018 The FSM SHALL have states IDLE, DATA, PARITY and OVERFLOW.
REQ-019 In IDLE with ENABLE_XFR=1, the block SHALL go to DATA, capture bit 11, set the bit counter to 1, and in the same cycle clear WORD_COUNT, PERR_COUNT, TRUNCATED, OVERFLOW and WR_ADDR.
REQ-020 In DATA, the block SHALL shift in one bit per channel per cycle and go to PARITY after bit 0 has been captured.
REQ-021 In PARITY, the block SHALL compute PERRn = (XOR of 12 data bits) XNOR SERIAL_INn.
REQ-022 The parity cycle SHALL register WR_EN=1, WR_ADDR and WR_DATA for exactly one cycle on the next edge (write latency 1 cycle after the parity bit is sampled).
REQ-023 WR_ADDR SHALL increment after each write, and WORD_COUNT SHALL increment by 1.
REQ-024 PERR_COUNT SHALL increment by 1 if PERR0 or PERR1 is set, saturating at 0xFFFF.
REQ-025 After PARITY with ENABLE_XFR=1, the block SHALL go to DATA for the next word, or to OVERFLOW if WORD_COUNT has reached MAX_WORDS.
REQ-026 The transmitter's ENABLE_XFR may fall on the same edge as the last parity sample; that parity cycle SHALL complete normally.
REQ-027 If ENABLE_XFR=0 is sampled in DATA or PARITY, the partial word SHALL be discarded, TRUNCATED set to 1, and the FSM returned to IDLE.
REQ-028 Any ENABLE_XFR=0 sample while BUSY (DATA, PARITY or OVERFLOW) SHALL produce XFR_DONE=1 for one cycle on the next edge.
REQ-029 In OVERFLOW, the block SHALL set the OVERFLOW flag, ignore serial data, never assert WR_EN, and go to IDLE when ENABLE_XFR=0 is sampled.
REQ-030 WR_ADDR SHALL never wrap within a transfer; the maximum written address is MAX_WORDS-1.
REQ-031 WORD_COUNT, PERR_COUNT and the flags SHALL hold their values in IDLE until the next transfer starts.

Reset
REQ-032 With RESET=1 on a rising edge, the block SHALL enter IDLE with all outputs at 0, taking priority over all inputs, including mid-word.
REQ-033 A transfer in progress at reset SHALL be abandoned with no XFR_DONE pulse.
REQ-034 A transfer whose ENABLE_XFR is still high when RESET deasserts SHALL be picked up as a new transfer from the next ENABLE_XFR=1 sample, with no resynchronisation to word boundaries.

Verification
REQ-035 Full transfer: 2048 words, DATA0 ramp 0,1,2..., DATA1 0,0xFFF,0xFFE..., all parity good -> 2048 writes; WR_ADDR 2047 carries DATA0=0x7FF and DATA1=0x801; WORD_COUNT=2048; PERR_COUNT=0; one XFR_DONE pulse; flags 0.
REQ-036 Parity error: invert the channel-1 parity bit of word 5 -> write at address 5 has PERR1=1 and PERR0=0; PERR_COUNT=1; other words clean.
REQ-037 Truncation: ENABLE_XFR drops after 6 bits of word 3 -> exactly 3 writes (addresses 0-2), WORD_COUNT=3, TRUNCATED=1, XFR_DONE pulse.
REQ-038 Overflow: ENABLE_XFR held for 2049 full words -> 2048 writes, OVERFLOW=1, no write at or beyond address 2047 after word 2047, XFR_DONE when ENABLE_XFR falls.
REQ-039 Reset mid-word: RESET for 1 cycle during bit 4 of word 10 -> no further WR_EN, XFR_DONE=0, all outputs 0.
REQ-040 Back-to-back: two 4-word transfers separated by 1 idle cycle -> second transfer writes addresses 0-3 and WORD_COUNT=4.

Source files
------------

// File: rtl/rd_deserializer.sv
// rd_deserializer
//
// Receives two parallel serial channels from the RD transmitter and turns
// each 13-bit frame (WORD_BITS data bits MSB first, then one odd-parity bit)
// into one 32-bit buffer write that carries both channels side by side.
//
// Ports
//   LOCAL_CLK   : sole clock, everything on the rising edge
//   RESET       : synchronous, active-high reset
//   ENABLE_XFR  : transfer-active strobe from the transmitter
//   SERIAL_IN0  : channel 0 serial data
//   SERIAL_IN1  : channel 1 serial data
//   WR_EN       : one-cycle buffer write strobe per complete word
//   WR_ADDR     : buffer address of the word presented on WR_DATA
//   WR_DATA     : {3'b0, PERR1, DATA1, 3'b0, PERR0, DATA0}
//   WORD_COUNT  : complete words written in the current/last transfer
//   PERR_COUNT  : words with a parity error on either channel (saturating)
//   BUSY        : high in DATA, PARITY or OVERFLOW
//   XFR_DONE    : one-cycle pulse when a transfer ends
//   TRUNCATED   : sticky, a partial word was discarded
//   OVERFLOW    : sticky, data arrived after the buffer was full

module rd_deserializer #(
  parameter int WORD_BITS = 12,
  parameter int MAX_WORDS = 2048,
  parameter int ADDR_BITS = 11
) (
  input  logic                 LOCAL_CLK,
  input  logic                 RESET,
  input  logic                 ENABLE_XFR,
  input  logic                 SERIAL_IN0,
  input  logic                 SERIAL_IN1,
  output logic                 WR_EN,
  output logic [ADDR_BITS-1:0] WR_ADDR,
  output logic [31:0]          WR_DATA,
  output logic [ADDR_BITS:0]   WORD_COUNT,
  output logic [15:0]          PERR_COUNT,
  output logic                 BUSY,
  output logic                 XFR_DONE,
  output logic                 TRUNCATED,
  output logic                 OVERFLOW
);

  localparam int CNT_BITS = $clog2(WORD_BITS + 1);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WORD_BITS - 1);
  localparam logic [ADDR_BITS:0]  LAST_WORD = (ADDR_BITS + 1)'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DATA     = 2'd1,
    ST_PARITY   = 2'd2,
    ST_OVERFLOW = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [WORD_BITS-1:0] shift0;
  logic [WORD_BITS-1:0] shift1;
  logic [CNT_BITS-1:0]  bit_cnt;

  // decoded actions for the current cycle
  logic start_xfr;
  logic shift_en;
  logic write_word;
  logic end_xfr;
  logic set_trunc;
  logic set_ovf;

  logic perr0;
  logic perr1;

  // A frame is good when the 13 bits together hold an odd number of ones,
  // so the error flag is the inverse of the total XOR.
  assign perr0 = ~(^shift0 ^ SERIAL_IN0);
  assign perr1 = ~(^shift1 ^ SERIAL_IN1);

  assign BUSY = (state != ST_IDLE);

  // Places one channel's data and parity flag into a 16-bit half of WR_DATA.
  function automatic logic [15:0] pack_lane(input logic [WORD_BITS-1:0] d,
                                            input logic p);
    logic [15:0] lane;
    lane = '0;
    lane[WORD_BITS-1:0] = d;
    lane[WORD_BITS] = p;
    return lane;
  endfunction

  // Next-state and action decode.
  // A low ENABLE_XFR in DATA with no bits of the new word captured yet is the
  // normal end of a transfer (the transmitter drops enable right after the
  // last parity bit), so only a word with some bits already in counts as
  // truncated. The parity cycle always completes its write, even when enable
  // falls on that very sample. The OVERFLOW flag is raised only once a
  // sample actually arrives after the buffer is full, so a transfer of
  // exactly MAX_WORDS words ends clean.
  always_comb begin
    state_next = state;
    start_xfr  = 1'b0;
    shift_en   = 1'b0;
    write_word = 1'b0;
    end_xfr    = 1'b0;
    set_trunc  = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ENABLE_XFR) begin
          state_next = ST_DATA;
          start_xfr  = 1'b1;
        end
      end
      ST_DATA: begin
        if (!ENABLE_XFR) begin
          state_next = ST_IDLE;
          end_xfr    = 1'b1;
          set_trunc  = (bit_cnt != '0);
        end else begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_next = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        write_word = 1'b1;
        if (!ENABLE_XFR) begin
          state_next = ST_IDLE;
          end_xfr    = 1'b1;
        end else if (WORD_COUNT == LAST_WORD) begin
          state_next = ST_OVERFLOW;
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_OVERFLOW: begin
        if (!ENABLE_XFR) begin
          state_next = ST_IDLE;
          end_xfr    = 1'b1;
        end else begin
          set_ovf = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge LOCAL_CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: shift registers, bit counter, write port and status.
  // WR_ADDR is taken from WORD_COUNT before it increments, so addresses run
  // 0..MAX_WORDS-1 and never wrap.
  always_ff @(posedge LOCAL_CLK) begin
    if (RESET) begin
      shift0     <= '0;
      shift1     <= '0;
      bit_cnt    <= '0;
      WR_EN      <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
      WORD_COUNT <= '0;
      PERR_COUNT <= '0;
      XFR_DONE   <= 1'b0;
      TRUNCATED  <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      WR_EN    <= write_word;
      XFR_DONE <= end_xfr;

      if (start_xfr) begin
        // the first enabled edge already carries the MSB of word 0
        shift0     <= {{(WORD_BITS-1){1'b0}}, SERIAL_IN0};
        shift1     <= {{(WORD_BITS-1){1'b0}}, SERIAL_IN1};
        bit_cnt    <= CNT_BITS'(1);
        WR_ADDR    <= '0;
        WORD_COUNT <= '0;
        PERR_COUNT <= '0;
        TRUNCATED  <= 1'b0;
        OVERFLOW   <= 1'b0;
      end

      if (shift_en) begin
        shift0  <= {shift0[WORD_BITS-2:0], SERIAL_IN0};
        shift1  <= {shift1[WORD_BITS-2:0], SERIAL_IN1};
        bit_cnt <= bit_cnt + CNT_BITS'(1);
      end

      if (write_word) begin
        WR_DATA    <= {pack_lane(shift1, perr1), pack_lane(shift0, perr0)};
        WR_ADDR    <= WORD_COUNT[ADDR_BITS-1:0];
        WORD_COUNT <= WORD_COUNT + 1'b1;
        bit_cnt    <= '0;
        if ((perr0 || perr1) && (PERR_COUNT != 16'hFFFF)) begin
          PERR_COUNT <= PERR_COUNT + 16'd1;
        end
      end

      if (set_trunc) begin
        TRUNCATED <= 1'b1;
      end

      if (set_ovf) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

endmodule
